// File: rtl/out_port_pkg.sv
// Shared types and constants for the output-port frame assembler.
// Holds FSM states, control opcodes, port selects and status bit positions.
package out_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [3:0] OP_START     = 4'h1;
    localparam logic [3:0] OP_COMMIT    = 4'h2;
    localparam logic [3:0] OP_CLEAR_ERR = 4'hF;

    localparam logic SEL_DATA = 1'b0;
    localparam logic SEL_CTRL = 1'b1;

    localparam int ST_BIT_FULL  = 3;
    localparam int ST_BIT_BUSY  = 2;
    localparam int ST_BIT_OVF   = 1;
    localparam int ST_BIT_PROTO = 0;

endpackage

// File: rtl/out_port_timeout.sv
// Idle watchdog: counts active cycles without a write, expires on count CYCLES-1.
// Latency: o_expire is combinational on the expiring cycle; no backpressure.
module out_port_timeout #(
    parameter int CYCLES = 1024
) (
    input  logic clock,
    input  logic resetb,
    input  logic i_active,
    input  logic i_kick,
    output logic o_expire
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;

    assign w_at_limit = (r_cnt == CW'(CYCLES - 1));
    assign o_expire   = i_active && !i_kick && w_at_limit;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_cnt <= '0;
        end else if (!i_active || i_kick || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/out_port_assembler.sv
// Assembles CPU nibble writes into a word, committing to the pads atomically; OUT_PORT_TIMEOUT_EN adds idle abort.
// Latency: outputs/status update 1 cycle after the strobe; no backpressure, one write accepted per cycle.
module out_port_assembler
    import out_port_pkg::*;
#(
    parameter int                     NIBBLES        = 4,
    parameter logic [4*NIBBLES-1:0]   RESET_WORD     = '0,
    parameter int                     TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [3:0]             wr_data,
    output logic [4*NIBBLES-1:0]   out_word,
    output logic [4*NIBBLES-1:0]   out_oe,
    output logic                   commit_pulse,
    output logic [3:0]             status
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_staging;
    logic [CW-1:0]   r_count;
    logic [W-1:0]    r_out_word;
    logic [W-1:0]    r_out_oe;
    logic            r_commit;
    logic            r_ovf_err;
    logic            r_proto_err;

    logic w_ctrl;
    logic w_start;
    logic w_commit;
    logic w_clear;
    logic w_data;
    logic w_last;
    logic w_do_commit;
    logic w_expire;

    assign w_ctrl      = wr_en && (wr_sel == SEL_CTRL);
    assign w_start     = w_ctrl && (wr_data == OP_START);
    assign w_commit    = w_ctrl && (wr_data == OP_COMMIT);
    assign w_clear     = w_ctrl && (wr_data == OP_CLEAR_ERR);
    assign w_data      = wr_en && (wr_sel == SEL_DATA);
    assign w_last      = (r_count == CW'(NIBBLES - 1));
    assign w_do_commit = w_commit && (r_state == FULL);

`ifdef OUT_PORT_TIMEOUT_EN
    out_port_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .resetb   (resetb),
        .i_active (r_state != IDLE),
        .i_kick   (wr_en),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = FILL;
        end else if (w_expire) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                FILL:    if (w_data && w_last) w_state_nxt = FULL;
                FULL:    if (w_commit)         w_state_nxt = IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        out_word                 = r_out_word;
        out_oe                   = r_out_oe;
        commit_pulse             = r_commit;
        status                   = 4'b0000;
        status[ST_BIT_FULL]      = (r_state == FULL);
        status[ST_BIT_BUSY]      = (r_state != IDLE);
        status[ST_BIT_OVF]       = r_ovf_err;
        status[ST_BIT_PROTO]     = r_proto_err;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_staging <= '0;
            r_count   <= '0;
        end else if (w_start || w_expire) begin
            r_staging <= '0;
            r_count   <= '0;
        end else if (w_data && (r_state == FILL)) begin
            r_staging <= {r_staging[W-5:0], wr_data};
            r_count   <= r_count + CW'(1);
        end
    end

    // The pads only ever see a complete staged frame; partial frames stay internal.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_out_word <= RESET_WORD;
            r_out_oe   <= '0;
            r_commit   <= 1'b0;
        end else begin
            r_commit <= w_do_commit;
            if (w_do_commit) begin
                r_out_word <= r_staging;
                r_out_oe   <= '1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_ovf_err   <= 1'b0;
            r_proto_err <= 1'b0;
        end else if (w_clear) begin
            r_ovf_err   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_data && (r_state == FULL)) begin
                r_ovf_err <= 1'b1;
            end
            if ((w_data && (r_state == IDLE)) || (w_commit && (r_state == FILL)) || w_expire) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_port_assembler.sv
// Scoreboard bench: a reference model predicts status per write and queues committed words.
// Committed words are popped and compared whenever commit_pulse is seen.
module tb_out_port_assembler;

`ifdef OUT_PORT_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif
    localparam logic [15:0] RST_WORD = 16'h0000;

    logic        clock;
    logic        resetb;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_data;
    logic [15:0] out_word;
    logic [15:0] out_oe;
    logic        commit_pulse;
    logic [3:0]  status;

    out_port_assembler #(
        .NIBBLES        (4),
        .RESET_WORD     (RST_WORD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .resetb       (resetb),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .out_word     (out_word),
        .out_oe       (out_oe),
        .commit_pulse (commit_pulse),
        .status       (status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: 0=idle 1=fill 2=full
    int          m_st   = 0;
    logic [15:0] m_stg  = '0;
    int          m_cnt  = 0;
    logic        m_ovf  = 1'b0;
    logic        m_prot = 1'b0;
    logic [15:0] m_word = RST_WORD;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_status();
        return {m_st == 2, m_st != 0, m_ovf, m_prot};
    endfunction

    task automatic model_step(input logic s, input logic [3:0] d);
        if (s) begin
            case (d)
                4'h1: begin m_st = 1; m_stg = '0; m_cnt = 0; end
                4'h2: begin
                    if (m_st == 2) begin
                        m_word = m_stg;
                        exp_q.push_back(m_stg);
                        m_st = 0;
                    end else if (m_st == 1) begin
                        m_prot = 1'b1;
                    end
                end
                4'hF: begin m_ovf = 1'b0; m_prot = 1'b0; end
                default: ;
            endcase
        end else begin
            if (m_st == 1) begin
                m_stg = {m_stg[11:0], d};
                m_cnt++;
                if (m_cnt == 4) m_st = 2;
            end else if (m_st == 2) begin
                m_ovf = 1'b1;
            end else begin
                m_prot = 1'b1;
            end
        end
    endtask

    // Called at a negedge; strobes for exactly one rising edge and checks at the next negedge.
    task automatic wr(input logic s, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_sel  = s;
        wr_data = d;
        model_step(s, d);
        @(negedge clock);
        wr_en = 1'b0;
        chk("status", {28'd0, status}, {28'd0, m_status()});
        chk("out_word", {16'd0, out_word}, {16'd0, m_word});
    endtask

    task automatic frame(input logic [15:0] w);
        wr(1'b1, 4'h1);
        for (int i = 3; i >= 0; i--) wr(1'b0, w[4*i +: 4]);
        wr(1'b1, 4'h2);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (resetb && commit_pulse) begin
            if (exp_q.size() == 0) begin
                chk("spurious_commit", 32'd1, 32'd0);
            end else begin
                chk("commit_word", {16'd0, out_word}, {16'd0, exp_q.pop_front()});
                chk("commit_oe", {16'd0, out_oe}, 32'h0000_FFFF);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb  = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_data = 4'h0;
        idle(3);
        chk("rst_word", {16'd0, out_word}, {16'd0, RST_WORD});
        chk("rst_oe", {16'd0, out_oe}, 32'd0);
        chk("rst_pulse", {31'd0, commit_pulse}, 32'd0);
        chk("rst_status", {28'd0, status}, 32'd0);
        resetb = 1'b1;
        idle(2);

        frame(16'hAB60);
        idle(2);
        chk("oe_after_commit", {16'd0, out_oe}, 32'h0000_FFFF);
        frame(16'h1337);
        idle(2);

        // Overflow: fifth nibble dropped
        wr(1'b1, 4'h1);
        for (int i = 1; i <= 5; i++) wr(1'b0, 4'(i));
        wr(1'b1, 4'h2);
        wr(1'b1, 4'hF);
        chk("clear_status", {28'd0, status}, 32'd0);

        // Early commit: protocol error, frame stays open
        wr(1'b1, 4'h1);
        wr(1'b0, 4'h1);
        wr(1'b0, 4'h2);
        wr(1'b1, 4'h2);
        wr(1'b1, 4'h7);
        wr(1'b0, 4'h3);
        wr(1'b0, 4'h4);
        wr(1'b1, 4'h2);
        wr(1'b1, 4'hF);

        // Data in IDLE, then restart mid-frame
        wr(1'b0, 4'h9);
        wr(1'b1, 4'hF);
        wr(1'b1, 4'h1);
        wr(1'b0, 4'hA);
        wr(1'b0, 4'hB);
        frame(16'hCDEF);
        idle(2);

        // Asynchronous reset mid-frame
        wr(1'b1, 4'h1);
        wr(1'b0, 4'hA);
        wr(1'b0, 4'hB);
        resetb = 1'b0;
        #1;
        chk("async_rst_word", {16'd0, out_word}, {16'd0, RST_WORD});
        chk("async_rst_status", {28'd0, status}, 32'd0);
        chk("async_rst_oe", {16'd0, out_oe}, 32'd0);
        m_st = 0; m_stg = '0; m_cnt = 0; m_ovf = 1'b0; m_prot = 1'b0; m_word = RST_WORD;
        idle(3);
        chk("rst_hold_pulse", {31'd0, commit_pulse}, 32'd0);
        resetb = 1'b1;
        idle(1);
        frame(16'hAB60);
        idle(2);

`ifdef OUT_PORT_TIMEOUT_EN
        wr(1'b1, 4'h1);
        wr(1'b0, 4'hA);
        idle(TO - 1);
        chk("to_not_yet", {28'd0, status}, 32'h4);
        idle(1);
        chk("to_expired", {28'd0, status}, 32'h1);
        chk("to_word", {16'd0, out_word}, {16'd0, m_word});
        m_st = 0; m_stg = '0; m_cnt = 0; m_prot = 1'b1;
        wr(1'b1, 4'h2);
        idle(2);
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
